// File: rtl/ks_serial_add_arb.sv
// Two-requester round-robin byte-serial adder built around one 8-bit Kogge-Stone slice.
// Optional subtract support is enabled with macro KS_SERIAL_ADD_ARB_SUB_EN.
module ks_serial_add_arb #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic                req1_valid,
   output logic                req0_ready,
   output logic                req1_ready,
   input  logic [8*NBYTES-1:0] req0_a,
   input  logic [8*NBYTES-1:0] req0_b,
   input  logic [8*NBYTES-1:0] req1_a,
   input  logic [8*NBYTES-1:0] req1_b,
`ifdef KS_SERIAL_ADD_ARB_SUB_EN
   input  logic                req0_sub,
   input  logic                req1_sub,
`endif
   output logic                res_valid,
   input  logic                res_ready,
   output logic [8*NBYTES-1:0] res_sum,
   output logic                res_cout,
   output logic                res_id
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, res_sum_q, res_sum_d;
   logic [KW-1:0]   k_q, k_d;
   logic            carry_q, carry_d, sub_q, sub_d;
   logic            res_cout_q, res_cout_d, res_id_q, res_id_d, last_q, last_d;
   logic            idle, accept, sel, sub_sel;
   logic [7:0]      op_a, op_b, ks_sum;
   logic            ks_cout;
   logic [7:0]      g0, p0, g1, p1, g2, p2, g3, prop;

   // Requester 0 wins a tie when requester 1 was served last, and vice versa.
   assign idle       = (state_q == StIdle) && !rst;
   assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
   assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);
   assign accept     = req0_ready || req1_ready;
   assign sel        = req1_ready;

`ifdef KS_SERIAL_ADD_ARB_SUB_EN
   assign sub_sel = sel ? req1_sub : req0_sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign op_a = a_q[{k_q, 3'b000} +: 8];
   assign op_b = b_q[{k_q, 3'b000} +: 8] ^ {8{sub_q}};

   // Kogge-Stone slice; carry-in is folded into the bit-0 generate term.
   always_comb begin
      prop    = op_a ^ op_b;
      p0      = prop;
      g0      = op_a & op_b;
      g0[0]   = g0[0] | (p0[0] & carry_q);
      g1      = g0 | (p0 & {g0[6:0], 1'b0});
      p1      = p0 & {p0[6:0], 1'b1};
      g2      = g1 | (p1 & {g1[5:0], 2'b00});
      p2      = p1 & {p1[5:0], 2'b11};
      g3      = g2 | (p2 & {g2[3:0], 4'b0000});
      ks_sum  = prop ^ {g3[6:0], carry_q};
      ks_cout = g3[7];
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sub_d      = sub_q;
      k_d        = k_q;
      carry_d    = carry_q;
      res_sum_d  = res_sum_q;
      res_cout_d = res_cout_q;
      res_id_d   = res_id_q;
      last_d     = last_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               a_d      = sel ? req1_a : req0_a;
               b_d      = sel ? req1_b : req0_b;
               sub_d    = sub_sel;
               carry_d  = sub_sel;
               k_d      = '0;
               res_id_d = sel;
               last_d   = sel;
               state_d  = StRun;
            end
         end
         StRun: begin
            res_sum_d[{k_q, 3'b000} +: 8] = ks_sum;
            carry_d = ks_cout;
            k_d     = k_q + KW'(1);
            if (k_q == KW'(NBYTES - 1)) begin
               k_d        = '0;
               res_cout_d = ks_cout;
               state_d    = StDone;
            end
         end
         StDone: begin
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         k_q        <= '0;
         carry_q    <= 1'b0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
         res_id_q   <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sub_q      <= sub_d;
         k_q        <= k_d;
         carry_q    <= carry_d;
         res_sum_q  <= res_sum_d;
         res_cout_q <= res_cout_d;
         res_id_q   <= res_id_d;
         last_q     <= last_d;
      end
   end

   assign res_valid = (state_q == StDone);
   assign res_sum   = res_sum_q;
   assign res_cout  = res_cout_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_ks_serial_add_arb.sv
// Directed bench for ks_serial_add_arb (NBYTES=4); subtract vectors run when
// KS_SERIAL_ADD_ARB_SUB_EN is defined.
module tb_ks_serial_add_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
`ifdef KS_SERIAL_ADD_ARB_SUB_EN
   logic        req0_sub = 1'b0, req1_sub = 1'b0;
`endif
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_sum;
   logic        res_cout, res_id;

   int n_cmp = 0;
   int n_err = 0;

   ks_serial_add_arb #(.NBYTES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
`ifdef KS_SERIAL_ADD_ARB_SUB_EN
      .req0_sub   (req0_sub),
      .req1_sub   (req1_sub),
`endif
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!res_valid && cnt < 20) begin
         tick();
         cnt++;
      end
   endtask

   // Single-requester transaction with res_ready held high; starts and ends in IDLE.
   task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_sum,
                         input logic exp_cout);
      int cnt;
      if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
      else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
      #1;
      chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_valid(cnt);
      chk({tag, "_latency"}, cnt, 4);
      chk({tag, "_sum"}, res_sum, exp_sum);
      chk({tag, "_cout"}, res_cout, exp_cout);
      chk({tag, "_id"}, res_id, id);
      tick();
      chk({tag, "_consumed"}, res_valid, 1'b0);
   endtask

   int          cnt, rose;
   int          gcyc[$], gid[$], rid[$];
   logic [31:0] rsum[$];

   initial begin
      // Reset, with a valid request pending that must not be granted.
      rst = 1'b1; res_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0001;
      tick(); tick();
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_sum", res_sum, 32'h0);
      chk("rst_cout", res_cout, 1'b0);
      chk("rst_id", res_id, 1'b0);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);

      // req0 0xFF + 1, operand changed after accept must not matter.
      rst = 1'b0;
      #1;
      chk("t1_ready0", req0_ready, 1'b1);
      chk("t1_ready1", req1_ready, 1'b0);
      tick();
      req0_a = 32'hDEAD_BEEF;
      req0_valid = 1'b0;
      wait_valid(cnt);
      chk("t1_latency", cnt, 4);
      chk("t1_sum", res_sum, 32'h0000_0100);
      chk("t1_cout", res_cout, 1'b0);
      chk("t1_id", res_id, 1'b0);

      // Stall in DONE with req1 waiting.
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_sum", res_sum, 32'h0000_0100);
         chk("hold_id", res_id, 1'b0);
         chk("hold_ready1", req1_ready, 1'b0);
      end
      res_ready = 1'b1;
      tick();
      chk("t2_idle_valid", res_valid, 1'b0);
      chk("t2_ready1", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      wait_valid(cnt);
      chk("t2_latency", cnt, 4);
      chk("t2_sum", res_sum, 32'h0);
      chk("t2_cout", res_cout, 1'b1);
      chk("t2_id", res_id, 1'b1);
      tick();
      chk("t2_consumed", res_valid, 1'b0);

      // Round robin with both requesters always valid.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_a = 32'h1; req0_b = 32'h2; req1_a = 32'h10; req1_b = 32'h20;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
         if (req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
         if (res_valid) begin rid.push_back(int'(res_id)); rsum.push_back(res_sum); end
         tick();
      end
      chk("rr_grants", gid.size(), 5);
      chk("rr_results", rid.size(), 4);
      for (int i = 0; i < 4 && i < gid.size(); i++) chk("rr_gid", gid[i], i % 2);
      for (int i = 0; i < 4 && i + 1 < gcyc.size(); i++)
         chk("rr_spacing", gcyc[i+1] - gcyc[i], 6);
      for (int i = 0; i < rid.size(); i++) begin
         chk("rr_rid", rid[i], i % 2);
         chk("rr_sum", rsum[i], (i % 2) ? 32'h30 : 32'h3);
      end

      // req0 was just accepted; reset in its second RUN cycle.
      tick();
      rst = 1'b1;
      tick();
      chk("mr_valid", res_valid, 1'b0);
      chk("mr_sum", res_sum, 32'h0);
      chk("mr_cout", res_cout, 1'b0);
      chk("mr_id", res_id, 1'b0);
      chk("mr_ready0", req0_ready, 1'b0);
      chk("mr_ready1", req1_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("mr_tie_ready0", req0_ready, 1'b1);
      chk("mr_tie_ready1", req1_ready, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rose = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (res_valid) rose++;
      end
      chk("mr_no_result", rose, 0);

      // Further add vectors.
      run_op("v3", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0);
      run_op("v4", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

`ifdef KS_SERIAL_ADD_ARB_SUB_EN
      req0_sub = 1'b1;
      run_op("sub0", 1'b0, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0);
      req0_sub = 1'b0;
      req1_sub = 1'b1;
      run_op("sub1", 1'b1, 32'h7, 32'h5, 32'h0000_0002, 1'b1);
      req1_sub = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ks_serial_add_arb.md
KS_SERIAL_ADD_ARB -- requirements
Module: ks_serial_add_arb

Interface
REQ-001 SHALL have parameter: NBYTES, default 4, operand width in bytes (legal 2..8).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester operand-valid.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  8*NBYTES  operands.
REQ-007 SHALL have ports: res_valid  output  1; res_ready  input  1; result handshake.
REQ-008 SHALL have ports: res_sum  output  8*NBYTES  result; res_cout  output  1  final carry; res_id  output  1  index of the served requester.

Function
REQ-009 SHALL contain exactly one 8-bit parallel-prefix (Kogge-Stone) adder slice with carry-in; all arithmetic goes through it, one byte per cycle, LSB byte first.
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 In IDLE, SHALL grant round-robin: one valid requester gets the grant; if both are valid, the grant goes to the requester not served last.
REQ-012 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; never both high.
REQ-013 On the reqN_valid & reqN_ready edge, SHALL latch operands, set res_id=N, byte index=0, carry=cin (REQ-021), go to RUN.
REQ-014 Each RUN cycle SHALL add byte k of A and B plus carry, write byte k of res_sum, update carry, increment k.
REQ-015 After byte NBYTES-1, SHALL go to DONE, set res_valid=1 and res_cout=final carry; res_valid rises exactly NBYTES cycles after the accept edge.
REQ-016 In DONE, res_valid, res_sum, res_cout and res_id SHALL hold stable until res_ready=1; on that edge, go to IDLE and clear res_valid.
REQ-017 SHALL NOT accept a new request in the cycle the result is consumed; minimum accept-to-accept spacing is NBYTES+2 cycles.
REQ-018 reqN_valid deassertion while not granted SHALL be legal and SHALL NOT affect the round-robin pointer; only accepted requests update it.
REQ-019 Operands SHALL be read only at the accept edge; later changes on req inputs SHALL NOT affect the result.

Reset
REQ-020 While rst=1 at a clock edge: state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, carry=0, byte index=0, last-served pointer=1 (requester 0 wins first tie); both ready outputs 0 during reset; reset mid-RUN/DONE abandons the operation with no res_valid pulse.

Configuration
REQ-021 Macro KS_SERIAL_ADD_ARB_SUB_EN: when defined, ports req0_sub/req1_sub (input 1) exist and are latched at accept; sub=1 inverts every B byte and sets initial carry=1 (A-B, res_cout=1 means no borrow). When undefined, the ports are absent, the operation is always A+B, and initial carry=0.

Verification
REQ-022 NBYTES=4, req0 A=0x000000FF B=0x00000001 -> res_sum=0x00000100, res_cout=0, res_id=0, res_valid 4 cycles after accept.
REQ-023 req1 A=0xFFFFFFFF B=0x00000001 -> res_sum=0x00000000, res_cout=1, res_id=1.
REQ-024 After reset, both valid continuously with res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; accept spacing 6 cycles.
REQ-025 res_ready=0 for 5 cycles in DONE -> res_valid=1 and outputs unchanged, both ready=0; res_ready=1 -> IDLE next cycle.
REQ-026 rst=1 on the 2nd RUN cycle -> next cycle all outputs 0, state IDLE; res_valid never rises for that operation; next tie grants requester 0.
REQ-027 With KS_SERIAL_ADD_ARB_SUB_EN, A=0x00000005 B=0x00000007 sub=1 -> res_sum=0xFFFFFFFE, res_cout=0; A=7 B=5 sub=1 -> 0x00000002, res_cout=1.
